cory_unpack_ser: RTL
====================

Name: cory_unpack_ser

Overview:
- Width down-converter that sits directly downstream of the 4-lane packer.
- Consumes one packed word of L lanes × N bits over a valid/ready handshake.
- Emits the word as L consecutive N-bit beats on a valid/ready output, flagging the final beat.
- Feeds narrow serial consumers (per-lane processing, narrow bus bridges) from the packed stream without bubbles.

Parameters:
N, 8, lane width in bits
L, 4, lanes per packed word; legal range 2..16
Z, N*L, packed input width; derived, do not override
CW, clog2(L), beat counter width; derived

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  synchronous active-low reset
i_a_v  input  1  packed word valid
i_a_d  input  Z  packed word; lane k = i_a_d[k*N +: N]
o_a_r  output  1  ready for packed word
o_z_v  output  1  beat valid
o_z_d  output  N  beat data
o_z_last  output  1  high on final beat of a word
i_z_r  input  1  beat ready

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low (reset_n sampled on rising clk).
- Reset values:
  - o_z_v=0, o_z_last=0, o_z_d=0.
  - Beat counter cnt=0, busy=0.
  - o_a_r=0 while reset_n=0; o_a_r=1 on the first cycle after release.
- Registers: word register wr[Z-1:0], counter cnt[CW-1:0], flag busy.
- State machine:
  - IDLE (busy=0): o_a_r=1, o_z_v=0. On i_a_v & o_a_r: wr<=i_a_d, cnt<=0, busy<=1 → BUSY.
  - BUSY (busy=1): o_z_v=1, o_z_d=wr[cnt*N +: N], o_z_last=(cnt==L-1).
    - On i_z_r & ~o_z_last: cnt<=cnt+1.
    - On i_z_r & o_z_last: if i_a_v, load the new word (wr<=i_a_d, cnt<=0, stay BUSY); else busy<=0 → IDLE.
- o_a_r = ~busy | (o_z_v & o_z_last & i_z_r). This combinational path from i_z_r to o_a_r is intentional; it gives zero-bubble back-to-back words.
- Latency: word accepted at edge t → beat 0 valid in cycle t+1.
- Throughput: exactly L beats per word; sustained 1 beat/cycle with i_z_r held high.
- Handshake rules:
  - While o_z_v=1 & i_z_r=0, o_z_d, o_z_last and o_z_v are held stable.
  - o_z_v never drops without a transfer.
  - wr never changes while busy except on the last-beat reload.
- Upstream stall: i_a_v=0 at last-beat transfer → o_z_v=0 the next cycle, no spurious beat.
- Counter wrap: cnt never exceeds L-1; reload resets it to 0. No modulo arithmetic is required for non-power-of-two L.
- Reset mid-word: the in-flight word is discarded and no further beats appear. The upstream word is not re-requested; it is lost by design.
- Simultaneous i_a_v with a non-last beat transfer: i_a_d is not accepted (o_a_r=0); the upstream holds.

Optional Feature:
- Macro CORY_UNPACK_SER_MSB_FIRST_EN.
- Defined: beats emitted from the highest lane down: o_z_d=wr[(L-1-cnt)*N +: N]. o_z_last still marks the L-th beat (lane 0).
- Undefined: lane 0 first (LSB first), as above.
- Handshake, latency and reset behaviour are identical in both builds.

Decomposition:
- The shared include (cory_defs) provides the clog2 constant function used for CW and the lane-slice macro.
- No sub-module is needed; the block is a single register-plus-counter FSM.
- Under SIM with CORY_MON defined, instantiate cory_monitor #(N) on the o_z port.

Test Plan:
1. N=8, L=4. One word 0x44332211, i_z_r=1 → beats 11,22,33,44 in cycles t+1..t+4; o_z_last only on 44; o_a_r high again in cycle t+4.
2. Three words back-to-back, i_a_v=1, i_z_r=1 → 12 contiguous beats, no bubble; o_a_r pulses only on each last beat.
3. Word 0xDDCCBBAA with i_z_r toggling 1,0,0,1,… → o_z_d held across stall cycles; sequence AA,BB,CC,DD intact, each beat exactly once.
4. reset_n low for 1 cycle after beat BB → next cycle o_z_v=0, o_a_r=0; after release o_a_r=1; a fresh word 0x04030201 emits 01..04.
5. Build with CORY_UNPACK_SER_MSB_FIRST_EN; word 0x44332211 → beats 44,33,22,11, o_z_last on 11.
6. L=3, N=4, word 0xCBA → beats A,B,C, cnt returns to 0, o_z_last on C; no 4th beat.

Source files
------------

// File: rtl/cory_unpack_ser_pkg.sv
// Shared types and constant helpers for the cory_unpack_ser width down-converter.
package cory_unpack_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Ceiling log2 usable in constant expressions (beat counter sizing).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < v) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cory_unpack_ser_if.sv
// Packed-word input and narrow-beat output handshakes of cory_unpack_ser.
interface cory_unpack_ser_if #(
  parameter int N = 8,
  parameter int L = 4
);
  localparam int Z = N * L;

  logic         i_a_v;
  logic [Z-1:0] i_a_d;
  logic         o_a_r;
  logic         o_z_v;
  logic [N-1:0] o_z_d;
  logic         o_z_last;
  logic         i_z_r;

  modport slave (
    input  i_a_v, i_a_d, i_z_r,
    output o_a_r, o_z_v, o_z_d, o_z_last
  );

  modport master (
    output i_a_v, i_a_d, i_z_r,
    input  o_a_r, o_z_v, o_z_d, o_z_last
  );
endinterface

// File: rtl/cory_unpack_ser.sv
// Splits one L x N packed word into L consecutive N-bit beats, flagging the last one.
// Build option: CORY_UNPACK_SER_MSB_FIRST_EN emits the highest lane first.
module cory_unpack_ser
  import cory_unpack_ser_pkg::*;
#(
  parameter int N = 8,
  parameter int L = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  cory_unpack_ser_if.slave bus
);

  localparam int Z  = N * L;
  localparam int CW = (clog2(L) < 1) ? 1 : clog2(L);

  state_t          state_r, state_nxt_s;
  logic [Z-1:0]    wr_r, wr_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic [CW-1:0]   lane_s;
  logic            busy_s, last_s, fire_last_s, load_s;
  logic [N-1:0]    beat_s;

  assign busy_s      = (state_r == BUSY);
  assign last_s      = busy_s & (cnt_r == CW'(L - 1));
  assign fire_last_s = last_s & bus.i_z_r;
  assign load_s      = bus.i_a_v & bus.o_a_r;

  // Ready while idle, or in the same cycle the last beat leaves: no bubble between words.
  assign bus.o_a_r    = reset_n & (~busy_s | fire_last_s);
  assign bus.o_z_v    = busy_s;
  assign bus.o_z_last = last_s;
  assign bus.o_z_d    = beat_s;

`ifdef CORY_UNPACK_SER_MSB_FIRST_EN
  assign lane_s = CW'(L - 1) - cnt_r;
`else
  assign lane_s = cnt_r;
`endif

  // Beat data mux; zero while idle so the bus is quiet after reset.
  always_comb begin
    beat_s = {N{1'b0}};
    if (busy_s) begin
      beat_s = wr_r[int'(lane_s)*N +: N];
    end else begin
      beat_s = {N{1'b0}};
    end
  end

  // Next-state logic: load, advance the beat counter, reload or drop back to idle.
  always_comb begin
    state_nxt_s = state_r;
    wr_nxt_s    = wr_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (load_s) begin
          wr_nxt_s    = bus.i_a_d;
          cnt_nxt_s   = {CW{1'b0}};
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (bus.i_z_r) begin
          if (!last_s) begin
            cnt_nxt_s = cnt_r + CW'(1);
          end else if (bus.i_a_v) begin
            wr_nxt_s  = bus.i_a_d;
            cnt_nxt_s = {CW{1'b0}};
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, word and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      wr_r    <= {Z{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      wr_r    <= wr_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

`ifdef SIM
`ifdef CORY_MON
  cory_monitor #(N) u_mon (
    .clk    (clk),
    .v      (bus.o_z_v),
    .d      (bus.o_z_d),
    .last   (bus.o_z_last),
    .r      (bus.i_z_r)
  );
`endif
`endif

endmodule
